// File: rtl/decoder_pkg.sv
// Shared constants and types for the N-COBS receive path.
// Holds framing bytes, decoder state encoding and the frame error codes.
package decoder_pkg;

    localparam logic [7:0] CobsDelim   = 8'h00;
    localparam logic [7:0] CobsMaxCode = 8'hFF;

    typedef enum logic [1:0] {
        SCode,
        SData,
        SDiscard
    } cobs_state_t;

    typedef enum logic [1:0] {
        CobsOk,
        CobsTrunc,
        CobsOvf
    } cobs_err_t;

endpackage

// File: rtl/cobs_word_packer.sv
// Packs decoded bytes little-endian into 32-bit words; partial word flushed on a clean frame end.
// Latency: one cycle from byte/frame-end input to word output (aligned with the decoder's byte outputs).
// Backpressure: none; consumer must accept every o_word_vld pulse.
module cobs_word_packer (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_byte_vld,
    input  logic [7:0]  i_byte_dat,
    input  logic        i_frame_end,
    input  logic        i_frame_ok,
    output logic [31:0] o_word_dat,
    output logic [2:0]  o_word_width,
    output logic        o_word_vld
);

    logic [23:0] r_buf;
    logic [1:0]  r_cnt;
    logic [31:0] r_word;
    logic [2:0]  r_width;
    logic        r_vld;

    // Unused upper bytes of r_buf stay zero, so a flushed partial word is zero-padded.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_buf   <= '0;
            r_cnt   <= '0;
            r_word  <= '0;
            r_width <= '0;
            r_vld   <= 1'b0;
        end else begin
            r_vld   <= 1'b0;
            r_word  <= '0;
            r_width <= '0;
            if (i_byte_vld) begin
                if (r_cnt == 2'd3) begin
                    r_word  <= {i_byte_dat, r_buf};
                    r_width <= 3'd4;
                    r_vld   <= 1'b1;
                    r_buf   <= '0;
                    r_cnt   <= '0;
                end else begin
                    r_buf[{r_cnt, 3'b000} +: 8] <= i_byte_dat;
                    r_cnt                       <= r_cnt + 2'd1;
                end
            end else if (i_frame_end) begin
                if (i_frame_ok && (r_cnt != 2'd0)) begin
                    r_word  <= {8'h00, r_buf};
                    r_width <= {1'b0, r_cnt};
                    r_vld   <= 1'b1;
                end
                r_buf <= '0;
                r_cnt <= '0;
            end
        end
    end

    assign o_word_dat   = r_word;
    assign o_word_width = r_width;
    assign o_word_vld   = r_vld;

endmodule

// File: rtl/n_cobs_decoder.sv
// COBS frame decoder for the UART receive path; COBS_DEC_PACK_EN adds a 32-bit word packer output.
// Latency: every accepted byte's response (data byte and/or frame_done) is registered, one cycle later.
// Backpressure: none; rx_valid is a strobe and every byte is consumed on the cycle it arrives.
module n_cobs_decoder
    import decoder_pkg::*;
#(
    parameter int MaxLen  = 256,
    parameter int LenBits = $clog2(MaxLen + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [7:0]         out_data,
    output logic               out_valid,
    output logic               frame_done,
    output logic [LenBits-1:0] frame_len,
    output cobs_err_t          frame_err
`ifdef COBS_DEC_PACK_EN
    ,
    output logic [31:0]        word_data,
    output logic [2:0]         word_width,
    output logic               word_valid
`endif
);

    localparam logic [LenBits-1:0] MaxLenC = LenBits'(MaxLen);

    cobs_state_t        r_state, w_state_nxt;
    logic [7:0]         r_cnt, w_cnt_nxt;
    logic               r_pend, w_pend_nxt;
    logic [LenBits-1:0] r_len, w_len_nxt;

    logic               w_full;
    logic               w_emit;
    logic [7:0]         w_emit_dat;
    logic               w_done;
    logic [LenBits-1:0] w_flen;
    cobs_err_t          w_ferr;

    logic [7:0]         r_out_data;
    logic               r_out_valid;
    logic               r_frame_done;
    logic [LenBits-1:0] r_frame_len;
    cobs_err_t          r_frame_err;

    assign w_full = (r_len == MaxLenC);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        w_len_nxt   = r_len;
        w_emit      = 1'b0;
        w_emit_dat  = rx_data;
        w_done      = 1'b0;
        w_flen      = r_len;
        w_ferr      = CobsOk;
        if (rx_valid) begin
            unique case (r_state)
                SCode: begin
                    if (rx_data == CobsDelim) begin
                        // The final group's implicit zero is dropped here.
                        w_done     = (r_len != '0) || r_pend;
                        w_len_nxt  = '0;
                        w_pend_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt   = rx_data - 8'd1;
                        w_pend_nxt  = (rx_data != CobsMaxCode);
                        w_state_nxt = (rx_data == 8'd1) ? SCode : SData;
                        if (r_pend) begin
                            if (w_full) begin
                                w_state_nxt = SDiscard;
                            end else begin
                                w_emit     = 1'b1;
                                w_emit_dat = CobsDelim;
                                w_len_nxt  = r_len + 1'b1;
                            end
                        end
                    end
                end
                SData: begin
                    if (rx_data == CobsDelim) begin
                        w_done      = 1'b1;
                        w_ferr      = CobsTrunc;
                        w_len_nxt   = '0;
                        w_pend_nxt  = 1'b0;
                        w_state_nxt = SCode;
                    end else if (w_full) begin
                        w_state_nxt = SDiscard;
                    end else begin
                        w_emit    = 1'b1;
                        w_len_nxt = r_len + 1'b1;
                        w_cnt_nxt = r_cnt - 8'd1;
                        if (r_cnt == 8'd1) begin
                            w_state_nxt = SCode;
                        end
                    end
                end
                SDiscard: begin
                    if (rx_data == CobsDelim) begin
                        w_done      = 1'b1;
                        w_flen      = MaxLenC;
                        w_ferr      = CobsOvf;
                        w_len_nxt   = '0;
                        w_pend_nxt  = 1'b0;
                        w_state_nxt = SCode;
                    end
                end
                default: w_state_nxt = SCode;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= SCode;
            r_cnt        <= '0;
            r_pend       <= 1'b0;
            r_len        <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_len  <= '0;
            r_frame_err  <= CobsOk;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_pend       <= w_pend_nxt;
            r_len        <= w_len_nxt;
            r_out_valid  <= w_emit;
            r_out_data   <= w_emit ? w_emit_dat : 8'h00;
            r_frame_done <= w_done;
            r_frame_len  <= w_done ? w_flen : '0;
            r_frame_err  <= w_done ? w_ferr : CobsOk;
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign frame_done = r_frame_done;
    assign frame_len  = r_frame_len;
    assign frame_err  = r_frame_err;

`ifdef COBS_DEC_PACK_EN
    cobs_word_packer u_packer (
        .i_clk        (clk_i),
        .i_reset      (reset_i),
        .i_byte_vld   (w_emit),
        .i_byte_dat   (w_emit_dat),
        .i_frame_end  (w_done),
        .i_frame_ok   (w_ferr == CobsOk),
        .o_word_dat   (word_data),
        .o_word_width (word_width),
        .o_word_vld   (word_valid)
    );
`endif

endmodule

// File: tb/tb_n_cobs_decoder.sv
// Bench for n_cobs_decoder: two instances (MaxLen 256 and 4) share one byte stream;
// a frame-level COBS model supplies expected bytes and frame results for both.
module tb_n_cobs_decoder;
    import decoder_pkg::*;

    localparam int ML0 = 256;
    localparam int ML1 = 4;
    localparam int LB0 = $clog2(ML0 + 1);
    localparam int LB1 = $clog2(ML1 + 1);

    logic           clk = 1'b0;
    logic           reset;
    logic [7:0]     rx_data;
    logic           rx_valid;
    logic [7:0]     od0, od1;
    logic           ov0, ov1, fd0, fd1;
    logic [LB0-1:0] fl0;
    logic [LB1-1:0] fl1;
    cobs_err_t      fe0, fe1;
`ifdef COBS_DEC_PACK_EN
    logic [31:0]    wd0, wd1;
    logic [2:0]     ww0, ww1;
    logic           wv0, wv1;
    logic [31:0]    exp_wd[$];
    int             exp_ww[$];
`endif

    int         checks = 0;
    int         failures = 0;
    bit         gaps = 1'b0;
    logic [7:0] exp_b [2][$];
    int         exp_fl [2][$];
    logic [1:0] exp_fe [2][$];
    logic       last_vld = 1'b0;
    logic       last_delim = 1'b0;
    logic       last_rst = 1'b1;

    always #5 clk = ~clk;

    n_cobs_decoder #(.MaxLen(ML0)) u_dut0 (
        .clk_i(clk), .reset_i(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .out_data(od0), .out_valid(ov0), .frame_done(fd0), .frame_len(fl0), .frame_err(fe0)
`ifdef COBS_DEC_PACK_EN
        , .word_data(wd0), .word_width(ww0), .word_valid(wv0)
`endif
    );

    n_cobs_decoder #(.MaxLen(ML1)) u_dut1 (
        .clk_i(clk), .reset_i(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .out_data(od1), .out_valid(ov1), .frame_done(fd1), .frame_len(fl1), .frame_err(fe1)
`ifdef COBS_DEC_PACK_EN
        , .word_data(wd1), .word_width(ww1), .word_valid(wv1)
`endif
    );

    // Decode one frame (bytes between delimiters) as a whole array.
    function automatic void model(input logic [7:0] f[$], input int maxlen, input bit term,
                                  output logic [7:0] o[$], output bit done, output int dlen,
                                  output logic [1:0] derr);
        int i;
        int k;
        bit pend;
        bit trunc;
        i = 0; pend = 1'b0; trunc = 1'b0; o = {};
        while (i < f.size()) begin
            k = int'(f[i]) - 1;
            if (pend) o.push_back(8'h00);
            pend = (f[i] != 8'hFF);
            i++;
            if (f.size() - i < k) trunc = term;
            for (int j = 0; j < k && i < f.size(); j++) begin
                o.push_back(f[i]);
                i++;
            end
        end
        done = term && (f.size() != 0);
        dlen = o.size();
        derr = CobsOk;
        if (o.size() > maxlen) begin
            o    = o[0:maxlen-1];
            dlen = maxlen;
            derr = CobsOvf;
        end else if (trunc) begin
            derr = CobsTrunc;
        end
    endfunction

    function automatic void cobs_enc(input logic [7:0] p[$], output logic [7:0] f[$]);
        int code_idx;
        int code;
        f = {8'h00}; code_idx = 0; code = 1;
        foreach (p[i]) begin
            if (p[i] == 8'h00) begin
                f[code_idx] = 8'(code); code_idx = f.size(); f.push_back(8'h00); code = 1;
            end else begin
                f.push_back(p[i]); code++;
                if (code == 255) begin
                    f[code_idx] = 8'hFF; code_idx = f.size(); f.push_back(8'h00); code = 1;
                end
            end
        end
        f[code_idx] = 8'(code);
    endfunction

    function automatic bit q_eq(input logic [7:0] a[$], input logic [7:0] b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

`ifdef COBS_DEC_PACK_EN
    function automatic void pack_words(input logic [7:0] o[$], input bit flush,
                                       output logic [31:0] wd[$], output int ww[$]);
        logic [31:0] w;
        int n;
        wd = {}; ww = {}; w = '0; n = 0;
        foreach (o[i]) begin
            w[8*n +: 8] = o[i]; n++;
            if (n == 4) begin wd.push_back(w); ww.push_back(4); w = '0; n = 0; end
        end
        if (flush && n != 0) begin wd.push_back(w); ww.push_back(n); end
    endfunction
`endif

    task automatic pin_model(input string name, input logic [7:0] f[$], input int maxlen, input bit term,
                             input logic [7:0] eo[$], input bit edone, input int elen, input logic [1:0] eerr);
        logic [7:0] o[$];
        bit done;
        int dlen;
        logic [1:0] derr;
        model(f, maxlen, term, o, done, dlen, derr);
        checks++;
        if (!q_eq(o, eo) || done != edone || (edone && (dlen != elen || derr != eerr))) begin
            failures++;
            $display("FAIL model_%s got n=%0d done=%0b len=%0d err=%0d exp n=%0d done=%0b len=%0d err=%0d",
                     name, o.size(), done, dlen, derr, eo.size(), edone, elen, eerr);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_data = 8'($urandom);
        if (gaps && $urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
    endtask

    task automatic push_frame(input logic [7:0] f[$], input bit term);
        logic [7:0] o[$];
        bit done;
        int dlen;
        logic [1:0] derr;
`ifdef COBS_DEC_PACK_EN
        logic [31:0] wd[$];
        int ww[$];
`endif
        for (int d = 0; d < 2; d++) begin
            model(f, (d == 0) ? ML0 : ML1, term, o, done, dlen, derr);
            foreach (o[j]) exp_b[d].push_back(o[j]);
            if (done) begin exp_fl[d].push_back(dlen); exp_fe[d].push_back(derr); end
`ifdef COBS_DEC_PACK_EN
            if (d == 0) begin
                pack_words(o, done && derr == CobsOk, wd, ww);
                foreach (wd[j]) begin exp_wd.push_back(wd[j]); exp_ww.push_back(ww[j]); end
            end
`endif
        end
        foreach (f[j]) send(f[j]);
        if (term) send(8'h00);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    always @(posedge clk) begin
        last_vld   <= rx_valid;
        last_delim <= rx_valid && (rx_data == 8'h00);
        last_rst   <= reset;
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic       ov, fd;
            logic [7:0] od, eb;
            int         fl, el;
            logic [1:0] fe, ee;
            ov = (d == 0) ? ov0 : ov1;
            od = (d == 0) ? od0 : od1;
            fd = (d == 0) ? fd0 : fd1;
            fl = (d == 0) ? int'(fl0) : int'(fl1);
            fe = (d == 0) ? fe0 : fe1;
            if (last_rst) begin
                checks++;
                if (ov || fd || od != 8'h00 || fl != 0 || fe != CobsOk) begin
                    failures++;
                    $display("FAIL reset_outputs dut%0d got valid=%0b done=%0b data=%h len=%0d err=%0d exp all zero",
                             d, ov, fd, od, fl, fe);
                end
            end else begin
                if (ov) begin
                    checks++;
                    if (exp_b[d].size() == 0 || !last_vld) begin
                        failures++;
                        $display("FAIL out_byte dut%0d got unexpected byte %h (expected queue %0d, prev valid %0b)",
                                 d, od, exp_b[d].size(), last_vld);
                    end else begin
                        eb = exp_b[d].pop_front();
                        if (od != eb) begin
                            failures++;
                            $display("FAIL out_byte dut%0d got %h exp %h", d, od, eb);
                        end
                    end
                end
                if (fd) begin
                    checks++;
                    if (exp_fl[d].size() == 0 || !last_delim) begin
                        failures++;
                        $display("FAIL frame_done dut%0d got unexpected done len=%0d err=%0d (prev delim %0b)",
                                 d, fl, fe, last_delim);
                    end else begin
                        el = exp_fl[d].pop_front();
                        ee = exp_fe[d].pop_front();
                        if (fl != el || fe != ee) begin
                            failures++;
                            $display("FAIL frame_done dut%0d got len=%0d err=%0d exp len=%0d err=%0d",
                                     d, fl, fe, el, ee);
                        end
                    end
                end
            end
        end
`ifdef COBS_DEC_PACK_EN
        if (!last_rst && wv0) begin
            logic [31:0] ewd;
            int ewn;
            checks++;
            if (exp_wd.size() == 0) begin
                failures++;
                $display("FAIL word dut0 got unexpected word %h width %0d", wd0, ww0);
            end else begin
                ewd = exp_wd.pop_front();
                ewn = exp_ww.pop_front();
                if (wd0 != ewd || int'(ww0) != ewn) begin
                    failures++;
                    $display("FAIL word dut0 got %h/%0d exp %h/%0d", wd0, ww0, ewd, ewn);
                end
            end
        end
`endif
    end

    initial begin
        logic [7:0] f[$];
        logic [7:0] e[$];
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        f = '{8'h03, 8'h11, 8'h22, 8'h02, 8'h33};
        e = '{8'h11, 8'h22, 8'h00, 8'h33};
        pin_model("basic", f, ML0, 1'b1, e, 1'b1, 4, CobsOk);
`ifdef COBS_DEC_PACK_EN
        begin
            logic [31:0] wd[$];
            int ww[$];
            pack_words(e, 1'b1, wd, ww);
            checks++;
            if (wd.size() != 1 || wd[0] != 32'h33002211 || ww[0] != 4) begin
                failures++;
                $display("FAIL model_pack got n=%0d exp word 33002211 width 4", wd.size());
            end
        end
`endif
        push_frame(f, 1'b1);

        f = '{8'h01, 8'h01, 8'h01};
        e = '{8'h00, 8'h00};
        pin_model("zeros", f, ML0, 1'b1, e, 1'b1, 2, CobsOk);
        push_frame(f, 1'b1);
        f = {}; e = {};
        pin_model("empty", f, ML0, 1'b1, e, 1'b0, 0, CobsOk);
        push_frame(f, 1'b1);
        push_frame(f, 1'b1);

        f = {8'hFF}; e = {};
        repeat (254) begin f.push_back(8'hAA); e.push_back(8'hAA); end
        f.push_back(8'h02); f.push_back(8'hBB); e.push_back(8'hBB);
        pin_model("maxcode", f, ML0, 1'b1, e, 1'b1, 255, CobsOk);
        push_frame(f, 1'b1);

        f = '{8'h05, 8'h11, 8'h22};
        e = '{8'h11, 8'h22};
        pin_model("trunc", f, ML0, 1'b1, e, 1'b1, 2, CobsTrunc);
        push_frame(f, 1'b1);
        f = '{8'h02, 8'h44};
        e = '{8'h44};
        pin_model("after_trunc", f, ML0, 1'b1, e, 1'b1, 1, CobsOk);
        push_frame(f, 1'b1);

        f = '{8'h07, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        e = '{8'h01, 8'h02, 8'h03, 8'h04};
        pin_model("overflow", f, ML1, 1'b1, e, 1'b1, 4, CobsOvf);
        push_frame(f, 1'b1);

        f = '{8'h03, 8'h11};
        e = '{8'h11};
        pin_model("prefix", f, ML0, 1'b0, e, 1'b0, 0, CobsOk);
        push_frame(f, 1'b0);
        pulse_reset();
        f = '{8'h02, 8'h55};
        push_frame(f, 1'b1);

        gaps = 1'b1;
        for (int n = 0; n < 70; n++) begin
            logic [7:0] p[$];
            logic [7:0] g[$];
            int kind;
            int len;
            kind = $urandom_range(0, 9);
            p = {}; g = {};
            if (kind <= 4) begin
                len = $urandom_range(0, 20);
                repeat (len) p.push_back(($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
                cobs_enc(p, g);
                push_frame(g, 1'b1);
            end else if (kind == 5) begin
                len = $urandom_range(240, 300);
                repeat (len) p.push_back(($urandom_range(0, 63) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
                cobs_enc(p, g);
                push_frame(g, 1'b1);
            end else if (kind <= 7) begin
                len = $urandom_range(1, 10);
                repeat (len) g.push_back(8'($urandom_range(1, 8)));
                push_frame(g, 1'b1);
            end else if (kind == 8) begin
                len = $urandom_range(5, 20);
                repeat (len) p.push_back(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
                cobs_enc(p, g);
                g = g[0:$urandom_range(0, g.size() - 1)];
                push_frame(g, 1'b0);
                pulse_reset();
            end else begin
                push_frame(g, 1'b1);
            end
        end

        repeat (5) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (exp_b[d].size() != 0 || exp_fl[d].size() != 0) begin
                failures++;
                $display("FAIL leftover dut%0d got %0d bytes and %0d frames never seen, exp 0",
                         d, exp_b[d].size(), exp_fl[d].size());
            end
        end
`ifdef COBS_DEC_PACK_EN
        checks++;
        if (exp_wd.size() != 0) begin
            failures++;
            $display("FAIL leftover_words got %0d words never seen, exp 0", exp_wd.size());
        end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
